n0_prime: RTL and testbench



---
 rtl/n0prime_pkg.sv | 15 +
 rtl/n0prime_step.sv | 20 ++
 rtl/n0_prime.sv | 121 ++++++++++++
 tb/tb_n0_prime.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n0prime_pkg.sv
// Shared types and width for the n0' (Montgomery constant) engine.
package n0prime_pkg;

  localparam int unsigned W = 1025;

  typedef logic [W-1:0] n0p_word_t;
  typedef logic [W:0]   n0p_acc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } n0p_state_t;

endpackage

// File: rtl/n0prime_step.sv
// One Hensel-lifting step: conditionally add q to the running accumulator and halve it.
module n0prime_step
  import n0prime_pkg::*;
(
  input  logic [W:0]   i_acc,
  input  logic [W-1:0] i_q,
  output logic [W:0]   o_acc_nxt,
  output logic         o_bit
);

  logic [W:0] w_sum;
  logic [W:0] w_pick;

  // acc never exceeds q, so the W+1-bit sum cannot carry out.
  assign w_sum     = i_acc + {1'b0, i_q};
  assign o_bit     = i_acc[0];
  assign w_pick    = o_bit ? w_sum : i_acc;
  assign o_acc_nxt = w_pick >> 1;

endmodule

// File: rtl/n0_prime.sv
// Bit-serial engine producing t = -q^-1 mod p and qinv = q^-1 mod p for power-of-two p.
// Optional macro N0PRIME_CHECK_EN adds an err output flagging even q or non-power-of-two p.
module n0_prime
  import n0prime_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] p,
  input  logic [W-1:0] q,
  output logic [W-1:0] t,
  output logic [W-1:0] qinv,
`ifdef N0PRIME_CHECK_EN
  output logic         err,
`endif
  output logic         done
);

  n0p_state_t r_state, w_state_nxt;
  n0p_acc_t   r_acc, w_acc_nxt;
  n0p_word_t  r_tr, w_tr_nxt;
  n0p_word_t  r_mask, w_mask_nxt;
  n0p_word_t  r_q, w_q_nxt;
  n0p_word_t  r_p, w_p_nxt;
  n0p_word_t  w_t_nxt, w_qinv_nxt;
  logic       w_done_nxt;
  n0p_acc_t   w_step_acc;
  logic       w_step_bit;

`ifdef N0PRIME_CHECK_EN
  logic       w_err_nxt;
  logic       w_bad;
  assign w_bad = ~r_q[0] || (r_p == '0) || ((r_p & (r_p - n0p_word_t'(1))) != '0);
`endif

  n0prime_step u_step (
    .i_acc     (r_acc),
    .i_q       (r_q),
    .o_acc_nxt (w_step_acc),
    .o_bit     (w_step_bit)
  );

  // Next-state and datapath update; a start coincident with done is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_tr_nxt    = r_tr;
    w_mask_nxt  = r_mask;
    w_q_nxt     = r_q;
    w_p_nxt     = r_p;
    w_t_nxt     = t;
    w_qinv_nxt  = qinv;
    w_done_nxt  = 1'b0;
`ifdef N0PRIME_CHECK_EN
    w_err_nxt   = err;
`endif
    case (r_state)
      IDLE: begin
        if (start && !done) begin
          w_q_nxt     = q;
          w_p_nxt     = p;
          w_acc_nxt   = n0p_acc_t'(1);
          w_tr_nxt    = '0;
          w_mask_nxt  = n0p_word_t'(1);
          w_state_nxt = ITER;
        end
      end
      ITER: begin
        // mask wrapping to zero bounds the run for malformed p.
        if ((r_mask == r_p) || (r_mask == '0)) begin
          w_state_nxt = FIN;
        end else begin
          w_acc_nxt  = w_step_acc;
          w_tr_nxt   = w_step_bit ? (r_tr | r_mask) : r_tr;
          w_mask_nxt = r_mask << 1;
        end
      end
      FIN: begin
        w_t_nxt     = r_tr;
        w_qinv_nxt  = (r_p - r_tr) & (r_p - n0p_word_t'(1));
        w_done_nxt  = 1'b1;
`ifdef N0PRIME_CHECK_EN
        w_err_nxt   = w_bad;
`endif
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_tr    <= '0;
      r_mask  <= '0;
      r_q     <= '0;
      r_p     <= '0;
      t       <= '0;
      qinv    <= '0;
      done    <= 1'b0;
`ifdef N0PRIME_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_tr    <= w_tr_nxt;
      r_mask  <= w_mask_nxt;
      r_q     <= w_q_nxt;
      r_p     <= w_p_nxt;
      t       <= w_t_nxt;
      qinv    <= w_qinv_nxt;
      done    <= w_done_nxt;
`ifdef N0PRIME_CHECK_EN
      err     <= w_err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_n0_prime.sv
// Self-checking bench for n0_prime against a Newton-iteration inverse model.
module tb_n0_prime;
  import n0prime_pkg::*;

  localparam int LIMIT = W + 10;

  logic      clk = 1'b0;
  logic      rst;
  logic      start;
  n0p_word_t p;
  n0p_word_t q;
  n0p_word_t t;
  n0p_word_t qinv;
  logic      done;
`ifdef N0PRIME_CHECK_EN
  logic      err;
`endif

  int total = 0;
  int bad   = 0;

  n0_prime dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .p     (p),
    .q     (q),
    .t     (t),
    .qinv  (qinv),
`ifdef N0PRIME_CHECK_EN
    .err   (err),
`endif
    .done  (done)
  );

  always #5 clk = ~clk;

  // q^-1 mod 2^W by Newton iteration, reduced to mod p.
  function automatic n0p_word_t model_qinv(input n0p_word_t pp, input n0p_word_t qq);
    n0p_word_t x   = n0p_word_t'(1);
    n0p_word_t two = n0p_word_t'(2);
    for (int i = 0; i < 11; i++) x = x * (two - qq * x);
    return x & (pp - n0p_word_t'(1));
  endfunction

  function automatic n0p_word_t model_t(input n0p_word_t pp, input n0p_word_t qq);
    return (pp - model_qinv(pp, qq)) & (pp - n0p_word_t'(1));
  endfunction

  function automatic n0p_word_t rand_word();
    n0p_word_t w = '0;
    for (int i = 0; i < 33; i++) w = (w << 32) | n0p_word_t'($urandom);
    return w;
  endfunction

  function automatic n0p_word_t pow2(input int k);
    n0p_word_t one = n0p_word_t'(1);
    return one << k;
  endfunction

  // Launch one computation and wait (bounded) for done; lat counts edges after the start edge.
  task automatic run_op(input n0p_word_t pp, input n0p_word_t qq, output int lat);
    @(posedge clk); #1;
    p = pp; q = qq; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_op(input string name, input n0p_word_t pp, input n0p_word_t qq, input int k);
    int lat;
    n0p_word_t et, eq;
    et = model_t(pp, qq);
    eq = model_qinv(pp, qq);
    run_op(pp, qq, lat);
    total++;
    if (lat !== k + 2) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, k + 2);
    end
    total++;
    if (t !== et) begin
      bad++; $display("FAIL %s t got=%0h want=%0h", name, t, et);
    end
    total++;
    if (qinv !== eq) begin
      bad++; $display("FAIL %s qinv got=%0h want=%0h", name, qinv, eq);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; p = '0; q = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (t !== '0 || qinv !== '0 || done !== 1'b0) begin
      bad++; $display("FAIL reset t=%0h qinv=%0h done=%b want 0/0/0", t, qinv, done);
    end
`ifdef N0PRIME_CHECK_EN
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL reset_err got=%b want=0", err);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int lat;
    n0p_word_t rsa, p32, prod, t0, q0;
    run_op(n0p_word_t'(16), n0p_word_t'(3), lat);
    total++;
    if (lat !== 6 || t !== n0p_word_t'(5) || qinv !== n0p_word_t'(11)) begin
      bad++; $display("FAIL p16q3 lat=%0d t=%0d qinv=%0d want 6/5/11", lat, t, qinv);
    end
    t0 = t; q0 = qinv;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || t !== t0 || qinv !== q0) begin
      bad++; $display("FAIL hold done=%b t=%0d qinv=%0d want 0/%0d/%0d", done, t, qinv, t0, q0);
    end
    run_op(n0p_word_t'(256), n0p_word_t'(5), lat);
    total++;
    if (t !== n0p_word_t'(51) || qinv !== n0p_word_t'(205)) begin
      bad++; $display("FAIL p256q5 t=%0d qinv=%0d want 51/205", t, qinv);
    end
    prod = (n0p_word_t'(5) * t + n0p_word_t'(1)) & n0p_word_t'(255);
    total++;
    if (prod !== '0) begin
      bad++; $display("FAIL p256q5_inv residue got=%0d want=0", prod);
    end
    check_op("p8q7", n0p_word_t'(8), n0p_word_t'(7), 3);
    check_op("p1q7", n0p_word_t'(1), n0p_word_t'(7), 0);
    total++;
    if (t !== '0 || qinv !== '0) begin
      bad++; $display("FAIL p1_zero t=%0h qinv=%0h want 0/0", t, qinv);
    end
    p32 = pow2(32);
    rsa = rand_word();
    rsa[W-1] = 1'b0; rsa[W-2] = 1'b1; rsa[0] = 1'b1;
    run_op(p32, rsa, lat);
    total++;
    if (lat !== 34) begin
      bad++; $display("FAIL rsa32 latency got=%0d want=34", lat);
    end
    prod = (rsa * t + n0p_word_t'(1)) & (p32 - n0p_word_t'(1));
    total++;
    if (prod !== '0) begin
      bad++; $display("FAIL rsa32_t residue got=%0h want=0", prod);
    end
    prod = (rsa * qinv) & (p32 - n0p_word_t'(1));
    total++;
    if (prod !== n0p_word_t'(1)) begin
      bad++; $display("FAIL rsa32_qinv residue got=%0h want=1", prod);
    end
    run_op(p32, n0p_word_t'(1), lat);
    total++;
    if (qinv !== n0p_word_t'(1) || t !== p32 - n0p_word_t'(1)) begin
      bad++; $display("FAIL q1_p32 t=%0h qinv=%0h want ffffffff/1", t, qinv);
    end
  endtask

  task automatic test_random();
    int k;
    n0p_word_t pp, qq, res;
    for (int n = 0; n < 24; n++) begin
      k  = (n < 4) ? (W - 4 + n) : int'($urandom_range(0, W - 1));
      if (k > W - 1) k = W - 1;
      pp = pow2(k);
      qq = rand_word();
      qq[0] = 1'b1;
      check_op($sformatf("rand%0d_k%0d", n, k), pp, qq, k);
      res = (qq * t + n0p_word_t'(1)) & (pp - n0p_word_t'(1));
      total++;
      if (res !== '0) begin
        bad++; $display("FAIL rand%0d residue got=%0h want=0", n, res);
      end
    end
  endtask

  task automatic test_restart_ignored();
    int lat, seen;
    n0p_word_t pp, qq, et, eq;
    pp = pow2(20);
    qq = rand_word(); qq[0] = 1'b1;
    et = model_t(pp, qq); eq = model_qinv(pp, qq);
    @(posedge clk); #1;
    p = pp; q = qq; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (lat == 5) begin start = 1'b1; p = n0p_word_t'(16); q = n0p_word_t'(3); end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    total++;
    if (lat !== 22 || t !== et || qinv !== eq) begin
      bad++; $display("FAIL restart lat=%0d t=%0h qinv=%0h want 22/%0h/%0h", lat, t, qinv, et, eq);
    end
    // start raised in the done cycle must be dropped
    start = 1'b1; p = n0p_word_t'(16); q = n0p_word_t'(3);
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    total++;
    if (seen !== 0 || t !== et) begin
      bad++; $display("FAIL start_at_done done_count=%0d t=%0h want 0/%0h", seen, t, et);
    end
  endtask

  task automatic test_back_to_back();
    check_op("b2b_a", pow2(9), n0p_word_t'(12345), 9);
    check_op("b2b_b", pow2(5), n0p_word_t'(77), 5);
  endtask

  task automatic test_reset_abort();
    int seen;
    @(posedge clk); #1;
    p = pow2(40); q = n0p_word_t'(999); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    total++;
    if (t !== '0 || qinv !== '0 || done !== 1'b0) begin
      bad++; $display("FAIL abort t=%0h qinv=%0h done=%b want 0/0/0", t, qinv, done);
    end
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL abort_nodone done_count=%0d want=0", seen);
    end
    check_op("after_abort", n0p_word_t'(16), n0p_word_t'(3), 4);
  endtask

  task automatic test_degenerate();
    int lat;
    run_op('0, n0p_word_t'(3), lat);
    total++;
    if (lat !== W + 2) begin
      bad++; $display("FAIL p0_term latency got=%0d want=%0d", lat, W + 2);
    end
`ifdef N0PRIME_CHECK_EN
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL p0_err got=%b want=1", err);
    end
`endif
    run_op(n0p_word_t'(12), n0p_word_t'(3), lat);
    total++;
    if (lat !== W + 2) begin
      bad++; $display("FAIL p12_term latency got=%0d want=%0d", lat, W + 2);
    end
  endtask

`ifdef N0PRIME_CHECK_EN
  task automatic test_err();
    int lat;
    run_op(n0p_word_t'(16), n0p_word_t'(4), lat);
    total++;
    if (err !== 1'b1 || lat !== 6) begin
      bad++; $display("FAIL err_even_q err=%b lat=%0d want 1/6", err, lat);
    end
    run_op(n0p_word_t'(12), n0p_word_t'(3), lat);
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL err_p12 got=%b want=1", err);
    end
    run_op(n0p_word_t'(16), n0p_word_t'(3), lat);
    total++;
    if (err !== 1'b0 || t !== n0p_word_t'(5)) begin
      bad++; $display("FAIL err_ok err=%b t=%0d want 0/5", err, t);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_restart_ignored();
    test_back_to_back();
    test_reset_abort();
    test_degenerate();
`ifdef N0PRIME_CHECK_EN
    test_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
